// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: raster scan generator for the 640x480@60 Hz display path.
// Issues video memory read addresses, takes back the 3-bit colour one Clock
// later, and drives the VGA sync/RGB pins. The colour path is aligned so that
// sync and colour leave the block together, one pixel behind the counters.
module vga_frame_scanner #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [2:0] iPixel,
    output logic [9:0] oVideoReadAddress,
    output logic [9:0] oColumnCount,
    output logic [9:0] oRowCount,
    output logic       oHorizontalSync,
    output logic       oVerticalSync,
    output logic       oRed,
    output logic       oGreen,
    output logic       oBlue,
    output logic       oFrameStart
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       toggle_q, toggle_d;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [2:0] rgb_q, rgb_d;
    logic       frame_start_q, frame_start_d;

    logic tick;
    logic col_wrap;
    logic row_wrap;
    logic visible;

    // Next-state: divider, counters and the output registers loaded on a tick.
    always_comb begin
        tick     = Enable & toggle_q;
        col_wrap = (col_q == H_LAST);
        row_wrap = (row_q == V_LAST);
        visible  = (col_q < H_VIS) && (row_q < V_VIS);

        toggle_d = toggle_q;
        col_d    = col_q;
        row_d    = row_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        rgb_d    = rgb_q;

        if (Enable) begin
            toggle_d = ~toggle_q;
        end

        if (tick) begin
            // Outputs use the pre-increment counters: iPixel belongs to them.
            hsync_d = !((col_q >= H_SYNC_FIRST) && (col_q <= H_SYNC_LAST));
            vsync_d = !((row_q >= V_SYNC_FIRST) && (row_q <= V_SYNC_LAST));
            rgb_d   = visible ? iPixel : 3'b000;
            col_d   = col_wrap ? 10'd0 : col_q + 10'd1;
            if (col_wrap) begin
                row_d = row_wrap ? 10'd0 : row_q + 10'd1;
            end
        end

        // Recomputed every Clock so the strobe stays one Clock wide even if
        // Enable drops right after the wrap.
        frame_start_d = tick & col_wrap & row_wrap;
    end

    // State registers with synchronous reset; reset outranks Enable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            toggle_q      <= 1'b0;
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            rgb_q         <= 3'b000;
            frame_start_q <= 1'b0;
        end else begin
            toggle_q      <= toggle_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    // 32x16 pixel cells; outside the visible area the address aliases harmlessly.
    always_comb begin
        oVideoReadAddress = {row_q[8:4], col_q[9:5]};
        oColumnCount      = col_q;
        oRowCount         = row_q;
        oHorizontalSync   = hsync_q;
        oVerticalSync     = vsync_q;
        {oRed, oGreen, oBlue} = rgb_q;
        oFrameStart       = frame_start_q;
    end

endmodule
